rf_wb_buffer: RTL and testbench



---
 rtl/rf_wb_buffer.sv | 96 +++++++++
 tb/tb_rf_wb_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_buffer.sv
// In-order write-back FIFO feeding the register-file write port, with a youngest-match lookup.
// Latency: a push at edge N is presented on wr_* from cycle N+1 onward; lookup is combinational.
// Backpressure: in_ready drops while full, and a pop in that same cycle does not reopen it.
module rf_wb_buffer #(
    parameter int ADDR_BITS = 3,
    parameter int DATA_BITS = 2,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_BITS-1:0]   in_addr,
    input  logic [DATA_BITS-1:0]   in_data,
    input  logic                   wr_slot,
    output logic                   wr_en,
    output logic [ADDR_BITS-1:0]   wr_addr,
    output logic [DATA_BITS-1:0]   wr_data,
    input  logic [ADDR_BITS-1:0]   lk_addr,
    output logic                   lk_hit,
    output logic [DATA_BITS-1:0]   lk_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    assign in_ready = (cnt != CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign wr_en    = !empty;
    assign wr_addr  = mem[rd_ptr].addr;
    assign wr_data  = mem[rd_ptr].data;
    assign push     = in_valid & in_ready;
    assign pop      = wr_en & wr_slot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            // push and pop never target the same slot: that needs count 0 or DEPTH
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: in_addr, data: in_data};
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (vld[idx] && (mem[idx].addr == lk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = mem[idx].data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_buffer.sv
module tb_rf_wb_buffer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_addr = '0;
    logic [1:0] in_data = '0;
    logic       wr_slot = 1'b0;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [1:0] wr_data;
    logic [2:0] lk_addr = '0;
    logic       lk_hit;
    logic [1:0] lk_data;
    logic [2:0] count;
    logic       empty;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] a;
        logic [1:0] d;
    } ent_t;

    ent_t q[$];     // pending writes, oldest first
    ent_t rf_log[$]; // writes the RF actually took, as seen on the DUT port

    rf_wb_buffer #(.ADDR_BITS(3), .DATA_BITS(2), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .wr_slot(wr_slot), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the queue model for the currently driven inputs.
    task automatic check_model();
        logic       e_hit;
        logic [1:0] e_dat;
        e_hit = 1'b0;
        e_dat = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == lk_addr) begin
                e_hit = 1'b1;
                e_dat = q[i].d;
                break;
            end
        end
        chk("in_ready", in_ready, (q.size() < DEPTH));
        chk("wr_en", wr_en, (q.size() > 0));
        chk("count", count, q.size());
        chk("empty", empty, (q.size() == 0));
        chk("lk_hit", lk_hit, e_hit);
        chk("lk_data", lk_data, e_dat);
        if (q.size() > 0) begin
            chk("wr_addr", wr_addr, q[0].a);
            chk("wr_data", wr_data, q[0].d);
        end
    endtask

    task automatic drive(input logic iv, input logic [2:0] ia, input logic [1:0] id,
                         input logic ws, input logic [2:0] la);
        @(negedge clk);
        in_valid = iv;
        in_addr  = ia;
        in_data  = id;
        wr_slot  = ws;
        lk_addr  = la;
        #1;
        check_model();
    endtask

    task automatic tick();
        logic m_push, m_pop;
        m_push = reset_n && in_valid && (q.size() < DEPTH);
        m_pop  = reset_n && wr_slot && (q.size() > 0);
        if (wr_en && wr_slot && reset_n) rf_log.push_back('{a: wr_addr, d: wr_data});
        @(posedge clk);
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back('{a: in_addr, d: in_data});
    endtask

    task automatic step(input logic iv, input logic [2:0] ia, input logic [1:0] id,
                        input logic ws, input logic [2:0] la);
        drive(iv, ia, id, ws, la);
        tick();
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset_n = 1'b0;
        q.delete();
        for (int i = 0; i < cycles; i++) begin
            drive(1'b0, 3'd0, 2'd0, 1'b1, 3'd0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_wr_en", wr_en, 0);
            chk("rst_empty", empty, 1);
            chk("rst_lk_hit", lk_hit, 0);
            tick();
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        ent_t exp_seq[$];

        // Reset and idle
        do_reset(2);
        drive(1'b0, 3'd0, 2'd0, 1'b0, 3'd0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_wr_en", wr_en, 0);
        chk("idle_count", count, 0);
        chk("idle_lk_data", lk_data, 0);
        tick();

        // Single push, no drain
        step(1'b1, 3'd5, 2'd2, 1'b0, 3'd5);
        drive(1'b0, 3'd0, 2'd0, 1'b0, 3'd5);
        chk("p1_wr_en", wr_en, 1);
        chk("p1_wr_addr", wr_addr, 5);
        chk("p1_wr_data", wr_data, 2);
        chk("p1_count", count, 1);
        chk("p1_lk_hit5", lk_hit, 1);
        chk("p1_lk_data5", lk_data, 2);
        tick();
        drive(1'b0, 3'd0, 2'd0, 1'b0, 3'd4);
        chk("p1_lk_hit4", lk_hit, 0);
        tick();

        // Mid-stream reset drops the pending write
        do_reset(3);
        drive(1'b0, 3'd0, 2'd0, 1'b0, 3'd5);
        chk("rst_drop_count", count, 0);
        chk("rst_drop_hit", lk_hit, 0);
        tick();

        // Fill, hold off a 5th request, then drain in order
        step(1'b1, 3'd1, 2'd1, 1'b0, 3'd0);
        step(1'b1, 3'd2, 2'd2, 1'b0, 3'd0);
        step(1'b1, 3'd3, 2'd3, 1'b0, 3'd0);
        step(1'b1, 3'd4, 2'd0, 1'b0, 3'd0);
        drive(1'b1, 3'd7, 2'd3, 1'b0, 3'd7);
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        tick();
        drive(1'b0, 3'd0, 2'd0, 1'b0, 3'd7);
        chk("held_count", count, 4);
        chk("held_lk_hit7", lk_hit, 0);
        tick();
        rf_log.delete();
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 2'd0, 1'b1, 3'd0);
        drive(1'b0, 3'd0, 2'd0, 1'b0, 3'd0);
        chk("drain_empty", empty, 1);
        tick();
        chk("drain_n", rf_log.size(), 4);
        for (int i = 0; i < rf_log.size() && i < 4; i++) chk("drain_addr", rf_log[i].a, i + 1);

        // Youngest match wins
        step(1'b1, 3'd6, 2'd1, 1'b0, 3'd6);
        step(1'b1, 3'd6, 2'd3, 1'b0, 3'd6);
        drive(1'b0, 3'd0, 2'd0, 1'b1, 3'd6);
        chk("yw_data0", lk_data, 3);
        tick();
        drive(1'b0, 3'd0, 2'd0, 1'b1, 3'd6);
        chk("yw_hit1", lk_hit, 1);
        chk("yw_data1", lk_data, 3);
        tick();
        drive(1'b0, 3'd0, 2'd0, 1'b0, 3'd6);
        chk("yw_hit2", lk_hit, 0);
        tick();

        // Streaming push+pop across two pointer wraps
        rf_log.delete();
        exp_seq.delete();
        for (int i = 0; i < 10; i++) begin
            logic [2:0] a;
            logic [1:0] d;
            a = 3'(i);
            d = 2'(i + 1);
            exp_seq.push_back('{a: a, d: d});
            drive(1'b1, a, d, 1'b1, 3'd0);
            if (i > 0) begin
                chk("stream_count", count, 1);
                chk("stream_wr_en", wr_en, 1);
            end
            tick();
        end
        step(1'b0, 3'd0, 2'd0, 1'b1, 3'd0);
        chk("stream_n", rf_log.size(), 10);
        for (int i = 0; i < rf_log.size() && i < 10; i++) begin
            chk("stream_addr", rf_log[i].a, exp_seq[i].a);
            chk("stream_data", rf_log[i].d, exp_seq[i].d);
        end

        // Full with simultaneous pop and request
        for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 2'(i), 1'b0, 3'd0);
        drive(1'b1, 3'd7, 2'd2, 1'b1, 3'd7);
        chk("fp_in_ready", in_ready, 0);
        tick();
        drive(1'b1, 3'd7, 2'd2, 1'b0, 3'd7);
        chk("fp_count", count, 3);
        chk("fp_in_ready2", in_ready, 1);
        chk("fp_lk_hit", lk_hit, 0);
        tick();
        drive(1'b0, 3'd0, 2'd0, 1'b0, 3'd7);
        chk("fp_count2", count, 4);
        chk("fp_lk_data", lk_data, 2);
        tick();

        // Randomized traffic, occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                step(1'($urandom_range(0, 99) < 60), 3'($urandom_range(0, 3)),
                     2'($urandom), 1'($urandom_range(0, 99) < 50), 3'($urandom_range(0, 3)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
